// File: rtl/m_useq_if.sv
// Microword/bus signal bundle between the decode datapath and the m_useq sequencer.
interface m_useq_if;
  logic [7:0] useq_next;
  logic       dispatch;
  logic [4:0] opcode_idx;
  logic [2:0] funct3;
  logic       start_shift;
  logic [4:0] shamt;
  logic       wait_req;
  logic       ack_i;
  logic       trap_req;
  logic       mret;
  logic       irq_pending;
  logic       irq_enable;
  logic [7:0] minx;
  logic       progress_ucode;
  logic       shift_active;
  logic       in_trap;

  modport master (
    output useq_next, dispatch, opcode_idx, funct3, start_shift, shamt,
           wait_req, ack_i, trap_req, mret, irq_pending, irq_enable,
    input  minx, progress_ucode, shift_active, in_trap
  );

  modport slave (
    input  useq_next, dispatch, opcode_idx, funct3, start_shift, shamt,
           wait_req, ack_i, trap_req, mret, irq_pending, irq_enable,
    output minx, progress_ucode, shift_active, in_trap
  );
endinterface

// File: rtl/m_useq.sv
// Microcode sequencer driving the ROM index and hold line; freezes during shifts and bus waits.
// Define USEQ_IRQ_EN to let opcode dispatch be redirected to IRQ_UADR on a pending, enabled interrupt.
module m_useq #(
  parameter logic [7:0] RESET_UADR = 8'h00,
  parameter logic [7:0] TRAP_UADR  = 8'hF0,
  parameter logic [7:0] IRQ_UADR   = 8'hF8
) (
  input logic      clk,
  input logic      rst,
  m_useq_if.slave  bus
);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0] state;
  logic [4:0] cnt;
  logic [7:0] saved_next;
  logic [7:0] minx_q;
  logic       in_trap_q;

  logic in_run;
  logic run_free;
  logic long_shift_start;
  logic wait_hold;

`ifndef USEQ_IRQ_EN
  logic irq_unused;
  assign irq_unused = ^{bus.irq_pending, bus.irq_enable, IRQ_UADR};
`endif

  // run_free: RUN with neither a trap nor a dispatch claiming this cycle
  assign in_run           = (state == RUN);
  assign run_free         = in_run && !bus.trap_req && !bus.dispatch;
  assign long_shift_start = run_free && bus.start_shift && (bus.shamt >= 5'd2);
  assign wait_hold        = run_free && !bus.start_shift && bus.wait_req && !bus.ack_i;

  assign bus.progress_ucode = !((!in_run && (cnt != 5'd1)) || long_shift_start || wait_hold);
  assign bus.shift_active   = !in_run || (run_free && bus.start_shift && (bus.shamt != 5'd0));
  assign bus.minx           = minx_q;
  assign bus.in_trap        = in_trap_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      minx_q     <= RESET_UADR;
      cnt        <= 5'd0;
      saved_next <= 8'h00;
      in_trap_q  <= 1'b0;
    end else if (in_run) begin
      // mret clears first so a same-cycle trap or irq entry overrides it
      if (bus.mret && !bus.trap_req)
        in_trap_q <= 1'b0;
      if (bus.trap_req) begin
        minx_q    <= TRAP_UADR;
        in_trap_q <= 1'b1;
      end else if (bus.dispatch) begin
`ifdef USEQ_IRQ_EN
        if (bus.irq_pending && bus.irq_enable) begin
          minx_q    <= IRQ_UADR;
          in_trap_q <= 1'b1;
        end else begin
          minx_q <= {bus.opcode_idx, bus.funct3};
        end
`else
        minx_q <= {bus.opcode_idx, bus.funct3};
`endif
      end else if (bus.start_shift) begin
        if (bus.shamt >= 5'd2) begin
          saved_next <= bus.useq_next;
          cnt        <= bus.shamt - 5'd1;
          state      <= SHIFT;
        end else begin
          minx_q <= bus.useq_next;
        end
      end else if (!(bus.wait_req && !bus.ack_i)) begin
        minx_q <= bus.useq_next;
      end
    end else begin
      // cnt counts remaining shift cycles including the current one
      cnt <= cnt - 5'd1;
      if (cnt == 5'd1) begin
        minx_q <= saved_next;
        state  <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_m_useq.sv
// Scoreboard bench for m_useq: per-cycle vectors carry expected outputs, popped and checked each cycle.
module tb_m_useq;

  typedef struct packed {
    logic       rst;
    logic [7:0] nxt;
    logic       disp;
    logic [4:0] opc;
    logic [2:0] f3;
    logic       ss;
    logic [4:0] sh;
    logic       wr;
    logic       ack;
    logic       trap;
    logic       mret;
    logic       irqp;
    logic       irqe;
    logic [7:0] em;
    logic       ep;
    logic       es;
    logic       et;
  } vec_t;

`ifdef USEQ_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   step;
  vec_t stim[$];
  vec_t sb[$];

  m_useq_if bus ();

  m_useq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t vec(input logic [7:0] nxt, input logic [7:0] em,
                               input logic ep, input logic es, input logic et);
    vec_t v;
    v     = '0;
    v.nxt = nxt;
    v.em  = em;
    v.ep  = ep;
    v.es  = es;
    v.et  = et;
    return v;
  endfunction

  // drives one cycle of inputs and records what the DUT owes for that cycle
  task automatic apply(input vec_t v);
    rst                 = v.rst;
    bus.useq_next       = v.nxt;
    bus.dispatch        = v.disp;
    bus.opcode_idx      = v.opc;
    bus.funct3          = v.f3;
    bus.start_shift     = v.ss;
    bus.shamt           = v.sh;
    bus.wait_req        = v.wr;
    bus.ack_i           = v.ack;
    bus.trap_req        = v.trap;
    bus.mret            = v.mret;
    bus.irq_pending     = v.irqp;
    bus.irq_enable      = v.irqe;
    sb.push_back(v);
  endtask

  task automatic test_reset();
    vec_t v, e;
    v = vec(8'h00, 8'h00, 1'b1, 1'b0, 1'b0); v.rst = 1'b1; stim.push_back(v);
    stim.push_back(vec(8'h12, 8'h12, 1'b1, 1'b0, 1'b0));
    while (stim.size() > 0) begin
      apply(stim.pop_front()); step++;
      @(negedge clk); e = sb[0]; n_cmp++;
      if ({bus.progress_ucode, bus.shift_active} !== {e.ep, e.es}) begin
        n_err++;
        $display("[TB] FAIL reset_comb step %0d: got prog=%b shift=%b, want prog=%b shift=%b", step, bus.progress_ucode, bus.shift_active, e.ep, e.es);
      end
      @(posedge clk); #1; e = sb.pop_front(); n_cmp++;
      if ({bus.minx, bus.in_trap} !== {e.em, e.et}) begin
        n_err++;
        $display("[TB] FAIL reset_reg step %0d: got minx=%h in_trap=%b, want minx=%h in_trap=%b", step, bus.minx, bus.in_trap, e.em, e.et);
      end
    end
  endtask

  task automatic test_dispatch();
    vec_t v, e;
    v = vec(8'h33, 8'h65, 1'b1, 1'b0, 1'b0); v.disp = 1'b1; v.opc = 5'h0C; v.f3 = 3'b101; stim.push_back(v);
    v = vec(8'h34, 8'hFF, 1'b1, 1'b0, 1'b0); v.disp = 1'b1; v.opc = 5'h1F; v.f3 = 3'b111; v.wr = 1'b1; stim.push_back(v);
    v = vec(8'h35, 8'h00, 1'b1, 1'b0, 1'b0); v.disp = 1'b1; v.ss = 1'b1; v.sh = 5'd5; stim.push_back(v);
    while (stim.size() > 0) begin
      apply(stim.pop_front()); step++;
      @(negedge clk); e = sb[0]; n_cmp++;
      if ({bus.progress_ucode, bus.shift_active} !== {e.ep, e.es}) begin
        n_err++;
        $display("[TB] FAIL dispatch_comb step %0d: got prog=%b shift=%b, want prog=%b shift=%b", step, bus.progress_ucode, bus.shift_active, e.ep, e.es);
      end
      @(posedge clk); #1; e = sb.pop_front(); n_cmp++;
      if ({bus.minx, bus.in_trap} !== {e.em, e.et}) begin
        n_err++;
        $display("[TB] FAIL dispatch_reg step %0d: got minx=%h in_trap=%b, want minx=%h in_trap=%b", step, bus.minx, bus.in_trap, e.em, e.et);
      end
    end
  endtask

  task automatic test_shift();
    vec_t v, e;
    stim.push_back(vec(8'h20, 8'h20, 1'b1, 1'b0, 1'b0));
    v = vec(8'h40, 8'h20, 1'b0, 1'b1, 1'b0); v.ss = 1'b1; v.sh = 5'd4; stim.push_back(v);
    v = vec(8'h99, 8'h20, 1'b0, 1'b1, 1'b0); v.disp = 1'b1; v.opc = 5'h1F; stim.push_back(v);
    stim.push_back(vec(8'h99, 8'h20, 1'b0, 1'b1, 1'b0));
    stim.push_back(vec(8'h99, 8'h40, 1'b1, 1'b1, 1'b0));
    v = vec(8'h41, 8'h41, 1'b1, 1'b0, 1'b0); v.ss = 1'b1; v.sh = 5'd0; stim.push_back(v);
    v = vec(8'h42, 8'h42, 1'b1, 1'b1, 1'b0); v.ss = 1'b1; v.sh = 5'd1; stim.push_back(v);
    v = vec(8'hFF, 8'h42, 1'b0, 1'b1, 1'b0); v.ss = 1'b1; v.sh = 5'd31; stim.push_back(v);
    for (int i = 0; i < 29; i++) stim.push_back(vec(8'h99, 8'h42, 1'b0, 1'b1, 1'b0));
    stim.push_back(vec(8'h99, 8'hFF, 1'b1, 1'b1, 1'b0));
    stim.push_back(vec(8'h00, 8'h00, 1'b1, 1'b0, 1'b0));
    while (stim.size() > 0) begin
      apply(stim.pop_front()); step++;
      @(negedge clk); e = sb[0]; n_cmp++;
      if ({bus.progress_ucode, bus.shift_active} !== {e.ep, e.es}) begin
        n_err++;
        $display("[TB] FAIL shift_comb step %0d: got prog=%b shift=%b, want prog=%b shift=%b", step, bus.progress_ucode, bus.shift_active, e.ep, e.es);
      end
      @(posedge clk); #1; e = sb.pop_front(); n_cmp++;
      if ({bus.minx, bus.in_trap} !== {e.em, e.et}) begin
        n_err++;
        $display("[TB] FAIL shift_reg step %0d: got minx=%h in_trap=%b, want minx=%h in_trap=%b", step, bus.minx, bus.in_trap, e.em, e.et);
      end
    end
  endtask

  task automatic test_wait();
    vec_t v, e;
    for (int i = 0; i < 3; i++) begin
      v = vec(8'h77, 8'h00, 1'b0, 1'b0, 1'b0); v.wr = 1'b1; stim.push_back(v);
    end
    v = vec(8'h77, 8'h77, 1'b1, 1'b0, 1'b0); v.wr = 1'b1; v.ack = 1'b1; stim.push_back(v);
    v = vec(8'h78, 8'h78, 1'b1, 1'b0, 1'b0); v.wr = 1'b1; v.ack = 1'b1; stim.push_back(v);
    v = vec(8'h50, 8'h78, 1'b0, 1'b1, 1'b0); v.wr = 1'b1; v.ss = 1'b1; v.sh = 5'd3; stim.push_back(v);
    v = vec(8'h90, 8'h78, 1'b0, 1'b1, 1'b0); v.wr = 1'b1; stim.push_back(v);
    v = vec(8'h91, 8'h50, 1'b1, 1'b1, 1'b0); v.wr = 1'b1; stim.push_back(v);
    stim.push_back(vec(8'h51, 8'h51, 1'b1, 1'b0, 1'b0));
    while (stim.size() > 0) begin
      apply(stim.pop_front()); step++;
      @(negedge clk); e = sb[0]; n_cmp++;
      if ({bus.progress_ucode, bus.shift_active} !== {e.ep, e.es}) begin
        n_err++;
        $display("[TB] FAIL wait_comb step %0d: got prog=%b shift=%b, want prog=%b shift=%b", step, bus.progress_ucode, bus.shift_active, e.ep, e.es);
      end
      @(posedge clk); #1; e = sb.pop_front(); n_cmp++;
      if ({bus.minx, bus.in_trap} !== {e.em, e.et}) begin
        n_err++;
        $display("[TB] FAIL wait_reg step %0d: got minx=%h in_trap=%b, want minx=%h in_trap=%b", step, bus.minx, bus.in_trap, e.em, e.et);
      end
    end
  endtask

  task automatic test_trap();
    vec_t v, e;
    v = vec(8'h11, 8'hF0, 1'b1, 1'b0, 1'b1); v.trap = 1'b1; v.disp = 1'b1; v.opc = 5'h0C; v.f3 = 3'b101; stim.push_back(v);
    v = vec(8'h13, 8'h13, 1'b1, 1'b0, 1'b0); v.mret = 1'b1; stim.push_back(v);
    v = vec(8'h12, 8'hF0, 1'b1, 1'b0, 1'b1); v.trap = 1'b1; v.mret = 1'b1; stim.push_back(v);
    v = vec(8'h12, 8'hF0, 1'b1, 1'b0, 1'b1); v.trap = 1'b1; v.ss = 1'b1; v.sh = 5'd3; stim.push_back(v);
    v = vec(8'h14, 8'h14, 1'b1, 1'b0, 1'b0); v.mret = 1'b1; stim.push_back(v);
    v = vec(8'h60, 8'h14, 1'b0, 1'b1, 1'b0); v.ss = 1'b1; v.sh = 5'd2; stim.push_back(v);
    v = vec(8'h61, 8'h60, 1'b1, 1'b1, 1'b0); v.trap = 1'b1; stim.push_back(v);
    v = vec(8'h62, 8'hF0, 1'b1, 1'b0, 1'b1); v.trap = 1'b1; stim.push_back(v);
    v = vec(8'h63, 8'hF0, 1'b0, 1'b0, 1'b0); v.wr = 1'b1; v.mret = 1'b1; stim.push_back(v);
    while (stim.size() > 0) begin
      apply(stim.pop_front()); step++;
      @(negedge clk); e = sb[0]; n_cmp++;
      if ({bus.progress_ucode, bus.shift_active} !== {e.ep, e.es}) begin
        n_err++;
        $display("[TB] FAIL trap_comb step %0d: got prog=%b shift=%b, want prog=%b shift=%b", step, bus.progress_ucode, bus.shift_active, e.ep, e.es);
      end
      @(posedge clk); #1; e = sb.pop_front(); n_cmp++;
      if ({bus.minx, bus.in_trap} !== {e.em, e.et}) begin
        n_err++;
        $display("[TB] FAIL trap_reg step %0d: got minx=%h in_trap=%b, want minx=%h in_trap=%b", step, bus.minx, bus.in_trap, e.em, e.et);
      end
    end
  endtask

  task automatic test_reset_mid();
    vec_t v, e;
    v = vec(8'h30, 8'hF0, 1'b1, 1'b0, 1'b1); v.trap = 1'b1; stim.push_back(v);
    v = vec(8'h70, 8'hF0, 1'b0, 1'b1, 1'b1); v.ss = 1'b1; v.sh = 5'd8; stim.push_back(v);
    v = vec(8'h71, 8'h00, 1'b0, 1'b1, 1'b0); v.rst = 1'b1; stim.push_back(v);
    stim.push_back(vec(8'h21, 8'h21, 1'b1, 1'b0, 1'b0));
    v = vec(8'h22, 8'h21, 1'b0, 1'b0, 1'b0); v.wr = 1'b1; stim.push_back(v);
    v = vec(8'h22, 8'h00, 1'b0, 1'b0, 1'b0); v.wr = 1'b1; v.rst = 1'b1; stim.push_back(v);
    stim.push_back(vec(8'h23, 8'h23, 1'b1, 1'b0, 1'b0));
    while (stim.size() > 0) begin
      apply(stim.pop_front()); step++;
      @(negedge clk); e = sb[0]; n_cmp++;
      if ({bus.progress_ucode, bus.shift_active} !== {e.ep, e.es}) begin
        n_err++;
        $display("[TB] FAIL rstmid_comb step %0d: got prog=%b shift=%b, want prog=%b shift=%b", step, bus.progress_ucode, bus.shift_active, e.ep, e.es);
      end
      @(posedge clk); #1; e = sb.pop_front(); n_cmp++;
      if ({bus.minx, bus.in_trap} !== {e.em, e.et}) begin
        n_err++;
        $display("[TB] FAIL rstmid_reg step %0d: got minx=%h in_trap=%b, want minx=%h in_trap=%b", step, bus.minx, bus.in_trap, e.em, e.et);
      end
    end
  endtask

  task automatic test_irq();
    vec_t v, e;
    v = vec(8'h40, 8'h65, 1'b1, 1'b0, 1'b0); v.disp = 1'b1; v.opc = 5'h0C; v.f3 = 3'b101; v.irqp = 1'b1; stim.push_back(v);
    v = vec(8'h41, IRQ_ON ? 8'hF8 : 8'h65, 1'b1, 1'b0, IRQ_ON);
    v.disp = 1'b1; v.opc = 5'h0C; v.f3 = 3'b101; v.irqp = 1'b1; v.irqe = 1'b1; stim.push_back(v);
    v = vec(8'h42, 8'h42, 1'b1, 1'b0, 1'b0); v.mret = 1'b1; stim.push_back(v);
    v = vec(8'h43, 8'hF0, 1'b1, 1'b0, 1'b1); v.trap = 1'b1; v.disp = 1'b1; v.irqp = 1'b1; v.irqe = 1'b1; stim.push_back(v);
    v = vec(8'h24, 8'h24, 1'b1, 1'b0, 1'b1); v.irqp = 1'b1; v.irqe = 1'b1; stim.push_back(v);
    v = vec(8'h25, 8'h25, 1'b1, 1'b0, 1'b0); v.mret = 1'b1; stim.push_back(v);
    while (stim.size() > 0) begin
      apply(stim.pop_front()); step++;
      @(negedge clk); e = sb[0]; n_cmp++;
      if ({bus.progress_ucode, bus.shift_active} !== {e.ep, e.es}) begin
        n_err++;
        $display("[TB] FAIL irq_comb step %0d: got prog=%b shift=%b, want prog=%b shift=%b", step, bus.progress_ucode, bus.shift_active, e.ep, e.es);
      end
      @(posedge clk); #1; e = sb.pop_front(); n_cmp++;
      if ({bus.minx, bus.in_trap} !== {e.em, e.et}) begin
        n_err++;
        $display("[TB] FAIL irq_reg step %0d: got minx=%h in_trap=%b, want minx=%h in_trap=%b", step, bus.minx, bus.in_trap, e.em, e.et);
      end
    end
  endtask

  initial begin
    vec_t v;
    n_cmp = 0;
    n_err = 0;
    step  = 0;
    v = '0;
    v.rst = 1'b1;
    apply(v);
    void'(sb.pop_front());
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_dispatch();
    test_shift();
    test_wait();
    test_trap();
    test_reset_mid();
    test_irq();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
